mem_wb_stage: RTL and testbench
===============================

// Module: mem_wb_stage
// PURPOSE
//   MEM/WB pipeline register for the P5 five-stage MIPS core: the receiving end of the MEM stage.
//   Captures PC, instruction, ALU result, data-memory read data and the lui shift value once per cycle.
//   Decodes the captured instruction into register-file write-back controls: W_RegWE, W_RegAddr and W_RegWD.
//   Keeps a retired-instruction counter for bench and debug.
// PARAMETERS
//   WIDTH     32  datapath width (PC, instruction, data)
//   RA_REG    31  link register index written by jal
//   LINK_OFF  8   offset added to PC for the jal link value
// PORTS
//   clk              in   1      rising-edge clock
//   reset            in   1      asynchronous, active-low reset
//   en               in   1      1 = capture inputs; 0 = stall (hold all state)
//   flush            in   1      1 = load a bubble (nop) instead of the inputs
//   in_PC            in   32     PC of the instruction in MEM
//   in_instruction   in   32     instruction word in MEM
//   in_ALUout        in   32     ALU result carried from EX/MEM
//   in_DMout         in   32     data-memory read data (lw)
//   in_Shift         in   32     lui result (imm16 << 16)
//   out_PC           out  32     registered PC
//   out_instruction  out  32     registered instruction
//   W_RegWE          out  1      register-file write enable
//   W_RegAddr        out  5      register-file write address
//   W_RegWD          out  32     register-file write data
//   retired_cnt      out  32     count of non-nop instructions accepted
// BEHAVIOUR
//   - Reset: while reset==0, all registers clear asynchronously to 0. All outputs then read 0 (W_RegWE=0).
//   - On each rising clk edge with reset==1, priority is flush > stall > capture:
//       flush=1        -> all data registers load 0 (instruction 0 = nop); counter unchanged.
//       flush=0, en=0  -> every register holds its value; counter unchanged.
//       flush=0, en=1  -> registers load the in_* values; counter +1 if in_instruction != 0.
//   - Counter wraps from 0xFFFFFFFF to 0.
//   - Latency: 1 cycle from inputs to outputs. Decode is combinational from the registered instruction only.
//   - Decode: op = instr[31:26], funct = instr[5:0].
//       op 000000, funct 100000 (add) or 100010 (sub) -> addr = instr[15:11], WD = ALUout.
//       op 000000, any other funct (nop, jr)          -> no write.
//       op 001101 (ori)                               -> addr = instr[20:16], WD = ALUout.
//       op 100011 (lw)                                -> addr = instr[20:16], WD = DMout.
//       op 001111 (lui)                               -> addr = instr[20:16], WD = Shift.
//       op 000011 (jal)                               -> addr = RA_REG, WD = PC + LINK_OFF (mod 2^32).
//       sw, beq and all other opcodes                 -> no write.
//   - "No write": W_RegWE=0, W_RegAddr=0, W_RegWD=0.
//   - W_RegWE is forced to 0 when the decoded address is 0. W_RegAddr and W_RegWD still show the decode.
//   - A flush and a stall in the same cycle: flush wins.
//   - A reset edge in the middle of a stall or flush overrides both immediately.
// TESTING
//   1. Reset low, then high; capture lw $8 (instr 0x8C080004) with DMout=0xDEADBEEF
//      -> next cycle: WE=1, Addr=8, WD=0xDEADBEEF, retired_cnt=1.
//   2. jal with in_PC=0x00003000 -> WE=1, Addr=31, WD=0x00003008.
//      lui $9 with Shift=0x12340000 -> Addr=9, WD=0x12340000.
//   3. add $0,$1,$2 (0x00220020) with ALUout=5 -> WE=0, Addr=0.
//      sw (0xAC080000) -> WE=0, Addr=0, WD=0.
//   4. Capture ori $3 (0x34030007), then en=0 for 3 cycles with random inputs
//      -> outputs unchanged and retired_cnt unchanged.
//   5. flush=1 together with en=0 and a valid add input
//      -> instruction=0, WE=0, counter unchanged.
//   6. Drive reset low asynchronously mid-cycle after 5 retired instructions
//      -> all outputs and retired_cnt read 0 before the next clk edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// -----------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register for the five-stage MIPS core. Captures the PC,
//   instruction, ALU result, data-memory read data and lui shift value once
//   per cycle. It then decodes the captured instruction into register-file
//   write-back controls, and keeps a count of retired (non-nop) instructions.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   en               1 = capture inputs, 0 = stall (hold all state)
//   flush            1 = load a bubble (nop); has priority over en
//   in_PC            PC of the instruction in MEM
//   in_instruction   instruction word in MEM
//   in_ALUout        ALU result from EX/MEM
//   in_DMout         data-memory read data (lw)
//   in_Shift         lui result (imm16 << 16)
//   out_PC           registered PC
//   out_instruction  registered instruction
//   W_RegWE          register-file write enable
//   W_RegAddr        register-file write address
//   W_RegWD          register-file write data
//   retired_cnt      number of non-nop instructions accepted (wraps)
// -----------------------------------------------------------------------------
module mem_wb_stage #(
   parameter int WIDTH    = 32,
   parameter int RA_REG   = 31,
   parameter int LINK_OFF = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic [WIDTH-1:0] in_PC,
   input  logic [WIDTH-1:0] in_instruction,
   input  logic [WIDTH-1:0] in_ALUout,
   input  logic [WIDTH-1:0] in_DMout,
   input  logic [WIDTH-1:0] in_Shift,
   output logic [WIDTH-1:0] out_PC,
   output logic [WIDTH-1:0] out_instruction,
   output logic             W_RegWE,
   output logic [4:0]       W_RegAddr,
   output logic [WIDTH-1:0] W_RegWD,
   output logic [WIDTH-1:0] retired_cnt
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;

   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_instr;
   logic [WIDTH-1:0] r_aluout;
   logic [WIDTH-1:0] r_dmout;
   logic [WIDTH-1:0] r_shift;
   logic [WIDTH-1:0] r_retired_cnt;

   logic [5:0]       w_op;
   logic [5:0]       w_funct;
   logic             w_wr;
   logic [4:0]       w_addr;
   logic [WIDTH-1:0] w_wd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc     <= '0;
         r_instr  <= '0;
         r_aluout <= '0;
         r_dmout  <= '0;
         r_shift  <= '0;
      end else if (flush) begin
         r_pc     <= '0;
         r_instr  <= '0;
         r_aluout <= '0;
         r_dmout  <= '0;
         r_shift  <= '0;
      end else if (en) begin
         r_pc     <= in_PC;
         r_instr  <= in_instruction;
         r_aluout <= in_ALUout;
         r_dmout  <= in_DMout;
         r_shift  <= in_Shift;
      end
   end

   // A flushed slot is a bubble, so it never counts as retired.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_retired_cnt <= '0;
      end else if (!flush && en && (in_instruction != '0)) begin
         r_retired_cnt <= r_retired_cnt + WIDTH'(1);
      end
   end

   assign w_op    = r_instr[31:26];
   assign w_funct = r_instr[5:0];

   always_comb begin
      w_wr   = 1'b0;
      w_addr = 5'd0;
      w_wd   = '0;
      case (w_op)
         OP_RTYPE: begin
            if ((w_funct == FN_ADD) || (w_funct == FN_SUB)) begin
               w_wr   = 1'b1;
               w_addr = r_instr[15:11];
               w_wd   = r_aluout;
            end
         end
         OP_ORI: begin
            w_wr   = 1'b1;
            w_addr = r_instr[20:16];
            w_wd   = r_aluout;
         end
         OP_LW: begin
            w_wr   = 1'b1;
            w_addr = r_instr[20:16];
            w_wd   = r_dmout;
         end
         OP_LUI: begin
            w_wr   = 1'b1;
            w_addr = r_instr[20:16];
            w_wd   = r_shift;
         end
         OP_JAL: begin
            w_wr   = 1'b1;
            w_addr = 5'(RA_REG);
            w_wd   = r_pc + WIDTH'(LINK_OFF);
         end
         default: begin
            w_wr = 1'b0;
         end
      endcase
   end

   // $0 is hard-wired zero: suppress the enable, but keep the decode visible.
   assign W_RegWE         = w_wr && (w_addr != 5'd0);
   assign W_RegAddr       = w_addr;
   assign W_RegWD         = w_wd;
   assign out_PC          = r_pc;
   assign out_instruction = r_instr;
   assign retired_cnt     = r_retired_cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wd;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] cnt;
   } obs_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        en = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] in_PC = '0;
   logic [31:0] in_instruction = '0;
   logic [31:0] in_ALUout = '0;
   logic [31:0] in_DMout = '0;
   logic [31:0] in_Shift = '0;
   logic [31:0] out_PC;
   logic [31:0] out_instruction;
   logic        W_RegWE;
   logic [4:0]  W_RegAddr;
   logic [31:0] W_RegWD;
   logic [31:0] retired_cnt;

   int   n_tests = 0;
   int   n_fail = 0;
   obs_t sb[$];
   obs_t got;
   obs_t exp_v;

   // reference model state
   logic [31:0] m_pc, m_instr, m_alu, m_dm, m_sh, m_cnt;

   mem_wb_stage #(.WIDTH(32), .RA_REG(31), .LINK_OFF(8)) dut (
      .clk(clk), .reset(reset), .en(en), .flush(flush),
      .in_PC(in_PC), .in_instruction(in_instruction), .in_ALUout(in_ALUout),
      .in_DMout(in_DMout), .in_Shift(in_Shift),
      .out_PC(out_PC), .out_instruction(out_instruction),
      .W_RegWE(W_RegWE), .W_RegAddr(W_RegAddr), .W_RegWD(W_RegWD),
      .retired_cnt(retired_cnt)
   );

   always #5 clk = ~clk;

   function automatic obs_t sample();
      return {W_RegWE, W_RegAddr, W_RegWD, out_PC, out_instruction, retired_cnt};
   endfunction

   function automatic obs_t model_out();
      obs_t o;
      logic [5:0] op;
      logic [5:0] fn;
      o = '0;
      o.pc = m_pc;
      o.instr = m_instr;
      o.cnt = m_cnt;
      op = m_instr[31:26];
      fn = m_instr[5:0];
      case (op)
         6'h00: if (fn == 6'h20 || fn == 6'h22) begin
                   o.addr = m_instr[15:11]; o.wd = m_alu;
                end
         6'h0D: begin o.addr = m_instr[20:16]; o.wd = m_alu; end
         6'h23: begin o.addr = m_instr[20:16]; o.wd = m_dm;  end
         6'h0F: begin o.addr = m_instr[20:16]; o.wd = m_sh;  end
         6'h03: begin o.addr = 5'd31;          o.wd = m_pc + 32'd8; end
         default: ;
      endcase
      o.we = (o.addr != 5'd0);
      return o;
   endfunction

   task automatic model_clear();
      m_pc = '0; m_instr = '0; m_alu = '0; m_dm = '0; m_sh = '0; m_cnt = '0;
   endtask

   // Drive one cycle of inputs, predict the result, push it, and advance to
   // just after the capturing edge.
   task automatic drive(input logic e, input logic f, input logic [31:0] pc,
                        input logic [31:0] ins, input logic [31:0] alu,
                        input logic [31:0] dm, input logic [31:0] sh);
      en = e; flush = f;
      in_PC = pc; in_instruction = ins; in_ALUout = alu; in_DMout = dm; in_Shift = sh;
      if (f) begin
         m_pc = '0; m_instr = '0; m_alu = '0; m_dm = '0; m_sh = '0;
      end else if (e) begin
         m_pc = pc; m_instr = ins; m_alu = alu; m_dm = dm; m_sh = sh;
         if (ins != 32'd0) m_cnt = m_cnt + 32'd1;
      end
      sb.push_back(model_out());
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      model_clear();
      #2;
      sb.push_back(model_out());
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL reset_state got=%h exp=%h", got, exp_v);
      end
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic test_lw();
      drive(1'b1, 1'b0, 32'h0000_1000, 32'h8C08_0004, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0);
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL lw got=%h exp=%h", got, exp_v);
      end
      n_tests++;
      if (W_RegWE !== 1'b1 || W_RegAddr !== 5'd8 || W_RegWD !== 32'hDEAD_BEEF || retired_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL lw_const got we=%b addr=%0d wd=%h cnt=%0d exp we=1 addr=8 wd=deadbeef cnt=1",
                  W_RegWE, W_RegAddr, W_RegWD, retired_cnt);
      end
   endtask

   task automatic test_jal_lui();
      drive(1'b1, 1'b0, 32'h0000_3000, 32'h0C00_0400, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333);
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL jal got=%h exp=%h", got, exp_v);
      end
      n_tests++;
      if (W_RegWE !== 1'b1 || W_RegAddr !== 5'd31 || W_RegWD !== 32'h0000_3008) begin
         n_fail++;
         $display("FAIL jal_const got we=%b addr=%0d wd=%h exp we=1 addr=31 wd=00003008",
                  W_RegWE, W_RegAddr, W_RegWD);
      end
      drive(1'b1, 1'b0, 32'h0000_3004, 32'h3C09_1234, 32'h4444_4444, 32'h5555_5555, 32'h1234_0000);
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL lui got=%h exp=%h", got, exp_v);
      end
      n_tests++;
      if (W_RegWE !== 1'b1 || W_RegAddr !== 5'd9 || W_RegWD !== 32'h1234_0000) begin
         n_fail++;
         $display("FAIL lui_const got we=%b addr=%0d wd=%h exp we=1 addr=9 wd=12340000",
                  W_RegWE, W_RegAddr, W_RegWD);
      end
   endtask

   task automatic test_no_write();
      logic [31:0] pool [6];
      pool = '{32'h0022_0020,   // add $0,$1,$2
               32'hAC08_0000,   // sw
               32'h0022_2022,   // sub $4
               32'h03E0_0008,   // jr $31
               32'h1022_0003,   // beq
               32'h3400_00FF};  // ori $0
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b0, 32'h0000_4000 + 32'(i*4), pool[i], 32'd5, 32'hCAFE_0000, 32'hBEEF_0000);
         got = sample(); exp_v = sb.pop_front(); n_tests++;
         if (got !== exp_v) begin
            n_fail++; $display("FAIL no_write[%0d] got=%h exp=%h", i, got, exp_v);
         end
         if (i == 0) begin
            n_tests++;
            if (W_RegWE !== 1'b0 || W_RegAddr !== 5'd0 || W_RegWD !== 32'd5) begin
               n_fail++;
               $display("FAIL add_r0_const got we=%b addr=%0d wd=%h exp we=0 addr=0 wd=5",
                        W_RegWE, W_RegAddr, W_RegWD);
            end
         end
         if (i == 1) begin
            n_tests++;
            if (W_RegWE !== 1'b0 || W_RegAddr !== 5'd0 || W_RegWD !== 32'd0) begin
               n_fail++;
               $display("FAIL sw_const got we=%b addr=%0d wd=%h exp we=0 addr=0 wd=0",
                        W_RegWE, W_RegAddr, W_RegWD);
            end
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] cnt_held;
      drive(1'b1, 1'b0, 32'h0000_5000, 32'h3403_0007, 32'h0000_0007, 32'h0, 32'h0);
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL ori got=%h exp=%h", got, exp_v);
      end
      cnt_held = m_cnt;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, $urandom(), $urandom(), $urandom(), $urandom(), $urandom());
         got = sample(); exp_v = sb.pop_front(); n_tests++;
         if (got !== exp_v) begin
            n_fail++; $display("FAIL stall[%0d] got=%h exp=%h", i, got, exp_v);
         end
      end
      n_tests++;
      if (W_RegWE !== 1'b1 || W_RegAddr !== 5'd3 || W_RegWD !== 32'd7 ||
          out_instruction !== 32'h3403_0007 || retired_cnt !== cnt_held) begin
         n_fail++;
         $display("FAIL stall_const got we=%b addr=%0d wd=%h ins=%h cnt=%0d exp we=1 addr=3 wd=7 ins=34030007 cnt=%0d",
                  W_RegWE, W_RegAddr, W_RegWD, out_instruction, retired_cnt, cnt_held);
      end
   endtask

   task automatic test_flush();
      logic [31:0] cnt_held;
      cnt_held = m_cnt;
      drive(1'b0, 1'b1, 32'h0000_6000, 32'h0022_2820, 32'h0000_0009, 32'h0, 32'h0);
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL flush_stall got=%h exp=%h", got, exp_v);
      end
      n_tests++;
      if (out_instruction !== 32'd0 || W_RegWE !== 1'b0 || retired_cnt !== cnt_held) begin
         n_fail++;
         $display("FAIL flush_const got ins=%h we=%b cnt=%0d exp ins=0 we=0 cnt=%0d",
                  out_instruction, W_RegWE, retired_cnt, cnt_held);
      end
      drive(1'b1, 1'b0, 32'h0000_6004, 32'h0022_2820, 32'h0000_0009, 32'h0, 32'h0);
      drive(1'b1, 1'b1, 32'h0000_6008, 32'h8C0A_0000, 32'h0, 32'h1, 32'h0);
      for (int i = 0; i < 2; i++) begin
         got = sample(); exp_v = sb.pop_front(); n_tests++;
         if (i == 1 && got !== exp_v) begin
            n_fail++; $display("FAIL flush_en got=%h exp=%h", got, exp_v);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pool [10];
      logic [31:0] ins;
      pool = '{32'h8C08_0004, 32'h0C00_0100, 32'h3C09_ABCD, 32'h0022_0020,
               32'h0022_2022, 32'h3403_0007, 32'hAC08_0000, 32'h0000_0000,
               32'h03E0_0008, 32'h0043_0820};
      for (int i = 0; i < 40; i++) begin
         ins = pool[$urandom_range(0, 9)];
         drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0),
               $urandom(), ins, $urandom(), $urandom(), $urandom());
         got = sample(); exp_v = sb.pop_front(); n_tests++;
         if (got !== exp_v) begin
            n_fail++; $display("FAIL b2b[%0d] got=%h exp=%h", i, got, exp_v);
         end
      end
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 1'b0, 32'h0000_7000 + 32'(i*4), 32'h3C09_0000 + 32'(i+1),
               32'h0, 32'h0, 32'h0001_0000 * 32'(i+1));
         got = sample(); exp_v = sb.pop_front(); n_tests++;
         if (got !== exp_v) begin
            n_fail++; $display("FAIL pre_reset[%0d] got=%h exp=%h", i, got, exp_v);
         end
      end
      en = 1'b0;
      #3;
      reset = 1'b0;
      model_clear();
      #1;
      sb.push_back(model_out());
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL async_reset got=%h exp=%h", got, exp_v);
      end
      en = 1'b1;
      in_instruction = 32'h8C08_0004;
      @(posedge clk);
      #1;
      sb.push_back(model_out());
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL reset_hold got=%h exp=%h", got, exp_v);
      end
      reset = 1'b1;
      drive(1'b1, 1'b0, 32'h0000_8000, 32'h8C08_0004, 32'h0, 32'h0000_0042, 32'h0);
      got = sample(); exp_v = sb.pop_front(); n_tests++;
      if (got !== exp_v) begin
         n_fail++; $display("FAIL post_reset got=%h exp=%h", got, exp_v);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_lw();
      test_jal_lui();
      test_no_write();
      test_stall();
      test_flush();
      test_back_to_back();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
